// File: rtl/tap_bram_arbiter.sv
// Single-port tap BRAM arbiter: AXI-Lite config path vs FIR engine bursts.
// Engine bursts lock the port; idle contention is resolved round-robin.
module tap_bram_arbiter #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,

    input  logic                   cfg_req,
    input  logic                   cfg_we,
    input  logic [pADDR_WIDTH-1:0] cfg_addr,
    input  logic [pDATA_WIDTH-1:0] cfg_wdata,
    output logic                   cfg_gnt,
    output logic                   cfg_rvalid,
    output logic [pDATA_WIDTH-1:0] cfg_rdata,
    output logic                   cfg_err,

    input  logic                   eng_req,
    input  logic                   eng_last,
    input  logic [pADDR_WIDTH-1:0] eng_addr,
    output logic                   eng_gnt,
    output logic                   eng_rvalid,
    output logic [pDATA_WIDTH-1:0] eng_rdata,
    output logic                   burst_err,

    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do
);

    localparam int BW = $clog2(Tape_Num + 1);
    localparam logic [pADDR_WIDTH-1:0] ADDR_MAX =
        pADDR_WIDTH'(4 * (Tape_Num - 1));

    typedef enum logic {
        IDLE,
        ENG_LOCK
    } state_t;

    // Read-return tag; CFG_ZERO marks an out-of-range config read.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_CFG,
        TAG_CFG_ZERO,
        TAG_ENG
    } tag_t;

    state_t        state;
    tag_t          tag;
    logic          rr;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_nxt;
    logic          cfg_bad;
    logic          cfg_wr_ok;
    logic          cap_hit;

    assign cfg_bad = (cfg_addr[1:0] != 2'b00) || (cfg_addr > ADDR_MAX);

    assign cfg_gnt = (state == IDLE) && cfg_req && (!eng_req || rr);
    assign eng_gnt = eng_req &&
                     ((state == ENG_LOCK) || !cfg_req || !rr);

    assign cfg_err   = cfg_gnt && cfg_bad;
    assign cfg_wr_ok = cfg_gnt && cfg_we && !cfg_bad;

    assign tap_EN = eng_gnt || (cfg_gnt && !(cfg_we && cfg_bad));
    assign tap_WE = cfg_wr_ok ? 4'hF : 4'h0;
    assign tap_Di = cfg_wr_ok ? cfg_wdata : '0;

    always_comb begin
        tap_A = '0;
        if (eng_gnt)
            tap_A = eng_addr;
        else if (cfg_gnt)
            tap_A = cfg_addr;
    end

    // Beat count after this grant; reaching Tape_Num without last forces release.
    assign bcnt_nxt = (state == IDLE) ? BW'(1) : bcnt + BW'(1);
    assign cap_hit  = !eng_last && (bcnt_nxt == BW'(Tape_Num));

    assign cfg_rvalid = (tag == TAG_CFG) || (tag == TAG_CFG_ZERO);
    assign cfg_rdata  = (tag == TAG_CFG) ? tap_Do : '0;
    assign eng_rvalid = (tag == TAG_ENG);
    assign eng_rdata  = (tag == TAG_ENG) ? tap_Do : '0;

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state     <= IDLE;
            tag       <= TAG_NONE;
            rr        <= 1'b0;
            bcnt      <= '0;
            burst_err <= 1'b0;
        end else begin
            tag <= TAG_NONE;
            if (eng_gnt)
                tag <= TAG_ENG;
            else if (cfg_gnt && !cfg_we)
                tag <= cfg_bad ? TAG_CFG_ZERO : TAG_CFG;

            if (cfg_gnt)
                rr <= 1'b0;

            if (eng_gnt) begin
                if (eng_last || cap_hit) begin
                    state <= IDLE;
                    bcnt  <= '0;
                    rr    <= 1'b1;
                    if (cap_hit)
                        burst_err <= 1'b1;
                end else begin
                    state <= ENG_LOCK;
                    bcnt  <= bcnt_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_tap_bram_arbiter.sv
// Directed self-checking bench for tap_bram_arbiter with a 1-cycle BRAM model.
module tb_tap_bram_arbiter;

    logic        axis_clk = 1'b0;
    logic        axis_rst;
    logic        cfg_req, cfg_we;
    logic [11:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_gnt, cfg_rvalid, cfg_err;
    logic [31:0] cfg_rdata;
    logic        eng_req, eng_last;
    logic [11:0] eng_addr;
    logic        eng_gnt, eng_rvalid, burst_err;
    logic [31:0] eng_rdata;
    logic [3:0]  tap_WE;
    logic        tap_EN;
    logic [31:0] tap_Di;
    logic [11:0] tap_A;
    logic [31:0] tap_Do;

    logic [31:0] mem [16];
    int checks = 0;
    int errors = 0;

    always #5 axis_clk = ~axis_clk;

    tap_bram_arbiter #(
        .pADDR_WIDTH(12),
        .pDATA_WIDTH(32),
        .Tape_Num   (11)
    ) dut (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .cfg_req   (cfg_req),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_gnt   (cfg_gnt),
        .cfg_rvalid(cfg_rvalid),
        .cfg_rdata (cfg_rdata),
        .cfg_err   (cfg_err),
        .eng_req   (eng_req),
        .eng_last  (eng_last),
        .eng_addr  (eng_addr),
        .eng_gnt   (eng_gnt),
        .eng_rvalid(eng_rvalid),
        .eng_rdata (eng_rdata),
        .burst_err (burst_err),
        .tap_WE    (tap_WE),
        .tap_EN    (tap_EN),
        .tap_Di    (tap_Di),
        .tap_A     (tap_A),
        .tap_Do    (tap_Do)
    );

    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF)
                mem[tap_A[5:2]] <= tap_Di;
            tap_Do <= mem[tap_A[5:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic idle_in();
        cfg_req  = 0;
        cfg_we   = 0;
        cfg_addr = '0;
        cfg_wdata = '0;
        eng_req  = 0;
        eng_last = 0;
        eng_addr = '0;
    endtask

    function automatic logic [31:0] tap_val(input int i);
        return (i == 2) ? 32'h5 : 32'h100 + 32'(i);
    endfunction

    initial begin
        for (int i = 0; i < 16; i++)
            mem[i] = 32'h100 + 32'(i);
        mem[11] = 32'hDEAD_BEEF;
        tap_Do = '0;
        idle_in();
        axis_rst = 1;
        cyc();
        cyc();
        axis_rst = 0;
        cyc();
        check("rst_cfg_rvalid", cfg_rvalid, 0);
        check("rst_eng_rvalid", eng_rvalid, 0);
        check("rst_burst_err", burst_err, 0);
        check("rst_tap_en", tap_EN, 0);
        check("rst_tap_a", tap_A, 0);

        // config write then readback
        cfg_req = 1; cfg_we = 1; cfg_addr = 12'h008; cfg_wdata = 32'h5;
        #1;
        check("wr_gnt", cfg_gnt, 1);
        check("wr_we", tap_WE, 4'hF);
        check("wr_a", tap_A, 12'h008);
        check("wr_di", tap_Di, 32'h5);
        check("wr_en", tap_EN, 1);
        cyc();
        cfg_we = 0;
        #1;
        check("rd_gnt", cfg_gnt, 1);
        check("rd_we", tap_WE, 0);
        check("rd_after_wr_rvalid", cfg_rvalid, 0);
        cyc();
        cfg_req = 0;
        #1;
        check("rd_rvalid", cfg_rvalid, 1);
        check("rd_rdata", cfg_rdata, 32'h5);
        check("rd_eng_rvalid", eng_rvalid, 0);

        // contention with single beats alternates, engine first
        cyc();
        cfg_req = 1; cfg_we = 0; cfg_addr = 12'h000;
        eng_req = 1; eng_last = 1; eng_addr = 12'h004;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("alt_eng_gnt", eng_gnt, (i % 2) == 0);
            check("alt_cfg_gnt", cfg_gnt, (i % 2) == 1);
            if (i > 0)
                check("alt_eng_rvalid", eng_rvalid, (i % 2) == 0 ? 0 : 1);
            cyc();
        end
        idle_in();
        cyc();

        // 11-beat burst, cfg raised at beat 3
        for (int k = 0; k < 11; k++) begin
            eng_req = 1; eng_addr = 12'(4 * k); eng_last = (k == 10);
            if (k >= 2) begin
                cfg_req = 1; cfg_we = 0; cfg_addr = 12'h00C;
            end
            #1;
            check("bur_eng_gnt", eng_gnt, 1);
            check("bur_cfg_gnt", cfg_gnt, 0);
            check("bur_tap_a", tap_A, 32'(4 * k));
            check("bur_rvalid", eng_rvalid, k > 0);
            if (k > 0)
                check("bur_rdata", eng_rdata, tap_val(k - 1));
            cyc();
        end
        eng_req = 0; eng_last = 0;
        #1;
        check("post_cfg_gnt", cfg_gnt, 1);
        check("post_rvalid", eng_rvalid, 1);
        check("post_rdata", eng_rdata, 32'h10A);
        cyc();
        cfg_req = 0;
        #1;
        check("post_cfg_rvalid", cfg_rvalid, 1);
        check("post_cfg_rdata", cfg_rdata, 32'h103);
        check("post_eng_rvalid", eng_rvalid, 0);

        // range checks
        cfg_req = 1; cfg_we = 1; cfg_addr = 12'h02C; cfg_wdata = 32'h77;
        #1;
        check("oor_wr_gnt", cfg_gnt, 1);
        check("oor_wr_err", cfg_err, 1);
        check("oor_wr_en", tap_EN, 0);
        check("oor_wr_we", tap_WE, 0);
        cyc();
        cfg_addr = 12'h006;
        #1;
        check("mis_wr_gnt", cfg_gnt, 1);
        check("mis_wr_err", cfg_err, 1);
        check("mis_wr_en", tap_EN, 0);
        cyc();
        cfg_we = 0; cfg_addr = 12'h02C;
        #1;
        check("oor_rd_err", cfg_err, 1);
        cyc();
        cfg_addr = 12'h028;
        #1;
        check("oor_rd_rvalid", cfg_rvalid, 1);
        check("oor_rd_rdata", cfg_rdata, 0);
        check("edge_rd_err", cfg_err, 0);
        check("edge_rd_en", tap_EN, 1);
        cyc();
        cfg_req = 0;
        #1;
        check("edge_rd_rdata", cfg_rdata, 32'h10A);
        check("mem_untouched", mem[2], 32'h5);

        // runaway burst with cfg contending throughout
        cfg_req = 1; cfg_we = 0; cfg_addr = 12'h004;
        for (int k = 0; k < 11; k++) begin
            eng_req = 1; eng_last = 0; eng_addr = 12'(4 * k);
            #1;
            check("run_eng_gnt", eng_gnt, 1);
            check("run_cfg_gnt", cfg_gnt, 0);
            check("run_berr", burst_err, 0);
            cyc();
        end
        #1;
        check("run_rel_cfg_gnt", cfg_gnt, 1);
        check("run_rel_eng_gnt", eng_gnt, 0);
        check("run_berr_set", burst_err, 1);
        cyc();
        idle_in();
        #1;
        check("run_cfg_rdata", cfg_rdata, 32'h101);
        check("run_berr_sticky", burst_err, 1);

        // reset at beat 5 of a burst
        for (int k = 0; k < 5; k++) begin
            eng_req = 1; eng_last = 0; eng_addr = 12'(4 * k);
            axis_rst = (k == 4);
            #1;
            check("mr_eng_gnt", eng_gnt, 1);
            cyc();
        end
        axis_rst = 0;
        cfg_req = 1; cfg_addr = 12'h000;
        eng_req = 1; eng_last = 1; eng_addr = 12'h000;
        #1;
        check("mr_eng_rvalid", eng_rvalid, 0);
        check("mr_berr", burst_err, 0);
        check("mr_eng_first", eng_gnt, 1);
        check("mr_cfg_wait", cfg_gnt, 0);
        cyc();
        #1;
        check("mr_cfg_next", cfg_gnt, 1);
        check("mr_eng_next", eng_gnt, 0);
        cyc();
        idle_in();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tap_bram_arbiter.md
# tap_bram_arbiter

Arbitrates the single-port tap-coefficient BRAM between two requesters: the AXI-Lite configuration path (coefficient write/readback) and the FIR engine (per-sample burst of Tape_Num coefficient reads). It sits between the AXI-Lite slave / FIR datapath and the tap RAM port. It grants one access per cycle, locks the port for an engine burst, and round-robins between requesters when both are idle-contending. It also range-checks addresses and returns read data with a 1-cycle BRAM latency.

## Interface
- pADDR_WIDTH, 12, BRAM byte-address width
- pDATA_WIDTH, 32, data width
- Tape_Num, 11, number of taps; valid word addresses 0..4*(Tape_Num-1)
- axis_clk  in  1  single clock; reset is synchronous and active-high
- axis_rst  in  1  synchronous active-high reset
- cfg_req  in  1  config access request; held until cfg_gnt
- cfg_we  in  1  1 = write, 0 = read
- cfg_addr  in  pADDR_WIDTH  byte address, tap-relative (0x20 offset already removed)
- cfg_wdata  in  pDATA_WIDTH  write data
- cfg_gnt  out  1  access issued this cycle
- cfg_rvalid  out  1  read data valid (cycle after granted read)
- cfg_rdata  out  pDATA_WIDTH  read data
- cfg_err  out  1  pulse with cfg_gnt when address out of range or misaligned
- eng_req  in  1  engine read request
- eng_last  in  1  marks final beat of engine burst
- eng_addr  in  pADDR_WIDTH  byte address
- eng_gnt  out  1  access issued this cycle
- eng_rvalid  out  1  read data valid
- eng_rdata  out  pDATA_WIDTH  read data
- burst_err  out  1  sticky: burst forcibly terminated; cleared by reset
- tap_WE  out  4  BRAM byte write enables
- tap_EN  out  1  BRAM enable
- tap_Di  out  pDATA_WIDTH  BRAM write data
- tap_A  out  pADDR_WIDTH  BRAM address
- tap_Do  in  pDATA_WIDTH  BRAM read data (1-cycle latency)

## Operation
- States: IDLE, ENG_LOCK. Round-robin pointer rr (1 = cfg favoured). Beat counter bcnt, width ceil(log2(Tape_Num+1)).
- IDLE: only cfg_req -> cfg_gnt. Only eng_req -> eng_gnt. Both -> winner per rr. Granting eng with eng_last=0 -> ENG_LOCK, bcnt=1. Eng grant with eng_last=1 -> stay IDLE, single beat.
- ENG_LOCK: cfg never granted. eng_req -> eng_gnt, bcnt+1. On eng_last granted -> IDLE. eng_req low -> hold lock, no access.
- Forced release: in ENG_LOCK, a grant making bcnt reach Tape_Num without eng_last -> that beat served, -> IDLE, burst_err set.
- rr update: after an eng single beat or burst end -> rr=1. After a cfg grant -> rr=0. Reset: rr=0 (engine first).
- Grants are combinational from state, rr, req. The access is driven onto tap_* in the same cycle: tap_EN=1, tap_A=granted addr.
- cfg write in range: tap_WE=4'hF, tap_Di=cfg_wdata. Otherwise tap_WE=0, tap_Di=0.
- Range check (cfg only): addr[1:0]!=0 or addr>4*(Tape_Num-1) -> cfg_err with cfg_gnt. A write is suppressed (tap_EN=0). A read returns rdata=0 with rvalid as normal. Engine addresses are not checked.
- Read return: a registered tag (none/cfg/eng) is captured at grant. Next cycle the tagged rvalid=1 and rdata=tap_Do (0 for error read). The untagged rdata=0.
- No grant -> tap_EN=0, tap_A=0.

## Timing
- Reset (synchronous, axis_rst=1 at posedge):
  - State and bookkeeping: state=IDLE, bcnt=0, rr=0, tag=none, burst_err=0.
  - Outputs: all outputs 0 the following cycle, except combinational grants, which track inputs from IDLE. A pending read return is dropped.
- Grant latency 0 cycles from req in a grantable state. Read latency 1 cycle (rvalid at cycle N+1 for grant at N).
- Back-to-back: one grant per cycle; the engine sustains Tape_Num reads in Tape_Num consecutive cycles under lock.
- Last beat at cycle N with cfg_req pending: cfg granted at N+1 (IDLE, rr=1).
- Reset asserted mid-burst: lock released. The next cycle a contending cfg vs eng goes to eng (rr=0).

## Test plan
- Reset then cfg write addr 0x08 data 0x5 -> same cycle cfg_gnt=1, tap_WE=F, tap_A=0x08, tap_Di=5. Read 0x08 -> cfg_rvalid next cycle, cfg_rdata=5.
- Eng burst of 11 reads addr 0..0x28, eng_last on 11th, cfg_req raised at beat 3 -> cfg_gnt stays 0 during burst. cfg granted cycle after beat 11. eng_rvalid on 11 consecutive cycles.
- Both req in IDLE, repeated single-beat (eng_last=1) -> grants alternate eng, cfg, eng, cfg starting with eng after reset.
- cfg write addr 0x2C and 0x06 -> cfg_gnt=1, cfg_err=1, tap_EN=0. cfg read 0x2C -> cfg_rvalid=1, cfg_rdata=0.
- Eng burst never asserting eng_last -> 11 grants, then IDLE, burst_err=1. Pending cfg granted next cycle.
- axis_rst pulsed at beat 5 of a burst -> next cycle state IDLE, eng_rvalid=0, burst_err=0. Contending reqs -> eng granted.
